// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory interface: responder FSM states
// and request field encodings used by the MEM stage and hazard unit.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/byte_lane_ram.sv
// Byte-addressed storage, big-endian: word at A is {mem[A], mem[A+1],
// mem[A+2], mem[A+3]}. Combinational 4-byte read at the word-aligned index
// of i_addr; synchronous write of either one byte or one aligned word.
module byte_lane_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we_byte,
    input  logic                  i_we_word,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [7:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] w_a0;
    logic [ADDR_WIDTH-1:0] w_a1;
    logic [ADDR_WIDTH-1:0] w_a2;
    logic [ADDR_WIDTH-1:0] w_a3;

    assign w_a0 = {i_addr[ADDR_WIDTH-1:2], 2'd0};
    assign w_a1 = {i_addr[ADDR_WIDTH-1:2], 2'd1};
    assign w_a2 = {i_addr[ADDR_WIDTH-1:2], 2'd2};
    assign w_a3 = {i_addr[ADDR_WIDTH-1:2], 2'd3};

    assign o_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};

    // Word write fills all four lanes; byte write touches only the addressed byte.
    always_ff @(posedge clk) begin
        if (i_we_word) begin
            r_mem[w_a0] <= i_wdata[31:24];
            r_mem[w_a1] <= i_wdata[23:16];
            r_mem[w_a2] <= i_wdata[15:8];
            r_mem[w_a3] <= i_wdata[7:0];
        end else if (i_we_byte) begin
            r_mem[i_addr] <= i_wdata[7:0];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder. Handshake: a request transfers on a rising edge
// where req_valid && req_ready; req_ready is high only in IDLE, so request
// inputs are ignored while an access is in flight. The access happens on
// the edge that enters RESP, and rsp_valid is a one-cycle pulse in RESP.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic                  req_size,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output state_t                dbg_state
);

    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_rw;
    logic                  r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    logic                  w_hs;
    logic                  w_direct;
    logic                  w_go;
    logic                  w_a_rw;
    logic                  w_a_size;
    logic [ADDR_WIDTH-1:0] w_a_addr;
    logic [31:0]           w_a_wdata;
    logic                  w_misaligned;
    logic                  w_we_word;
    logic                  w_we_byte;
    logic [31:0]           w_ram_rdata;
    logic [7:0]            w_byte;

    assign w_hs     = req_valid && req_ready;
    // With no wait states the accept edge is also the RESP entry edge, so
    // the access uses the values being latched on that same edge.
    assign w_direct = NO_WAIT && w_hs;
    assign w_go     = w_direct || ((r_state == WAIT) && (r_cnt == 4'd0));

    assign w_a_rw    = w_direct ? req_rw    : r_rw;
    assign w_a_size  = w_direct ? req_size  : r_size;
    assign w_a_addr  = w_direct ? req_addr  : r_addr;
    assign w_a_wdata = w_direct ? req_wdata : r_wdata;

    assign w_misaligned = (w_a_size == SIZE_WORD) && (w_a_addr[1:0] != 2'b00);

    // Reset on the RESP entry edge abandons the access, including its write.
    assign w_we_word = w_go && !reset && (w_a_rw == RW_WRITE) &&
                       (w_a_size == SIZE_WORD) && !w_misaligned;
    assign w_we_byte = w_go && !reset && (w_a_rw == RW_WRITE) &&
                       (w_a_size == SIZE_BYTE);

    assign dbg_state = r_state;

    byte_lane_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_we_byte (w_we_byte),
        .i_we_word (w_we_word),
        .i_addr    (w_a_addr),
        .i_wdata   (w_a_wdata),
        .o_rdata   (w_ram_rdata)
    );

    // Select the addressed byte out of the big-endian word.
    always_comb begin
        w_byte = 8'h00;
        case (w_a_addr[1:0])
            2'd0:    w_byte = w_ram_rdata[31:24];
            2'd1:    w_byte = w_ram_rdata[23:16];
            2'd2:    w_byte = w_ram_rdata[15:8];
            default: w_byte = w_ram_rdata[7:0];
        endcase
    end

    // Responder FSM with registered handshake, busy and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_rw      <= RW_READ;
            r_size    <= SIZE_BYTE;
            r_addr    <= '0;
            r_wdata   <= 32'h0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_rw      <= req_rw;
                        r_size    <= req_size;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (NO_WAIT) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
            if (w_go) begin
                rsp_valid <= 1'b1;
                if (w_misaligned) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end else if (w_a_rw == RW_READ) begin
                    rsp_rdata <= (w_a_size == SIZE_WORD) ? w_ram_rdata : {24'h0, w_byte};
                end
            end
        end
    end

endmodule
